// File: rtl/clk_step_pkg.sv
// Shared constants and types for the clock-source stage feeding the JK flip-flop experiment.
package clk_step_pkg;

  localparam logic MODE_FREE = 1'b0;
  localparam logic MODE_STEP = 1'b1;

  localparam int DEF_DIV_HALF   = 27000000;
  localparam int DEF_DEB_CYCLES = 270000;
  localparam int DEF_PULSE_LEN  = 1350000;
  localparam int DEF_CNT_W      = 27;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } deb_state_t;

endpackage

// File: rtl/clk_step_gen_if.sv
// Switch/button inputs and clock outputs of the clock-source stage.
interface clk_step_gen_if;

  logic CLKen;
  logic MODE;
  logic CP;
  logic CLKout;
  logic STEPBUSY;

  modport master (output CLKen, MODE, CP, input CLKout, STEPBUSY);
  modport slave  (input CLKen, MODE, CP, output CLKout, STEPBUSY);

endinterface

// File: rtl/btn_debounce.sv
// Push-button synchronizer and debounce FSM; emits one press_req pulse per physical press.
module btn_debounce
  import clk_step_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic exCLK,
  input  logic RST,
  input  logic btn,
  output logic press_req
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [1:0]       sync_reg;
  logic [1:0]       vld_reg;
  logic             armed_reg, armed_next;
  deb_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             press_reg, press_next;
  logic             cp_s;

  assign cp_s      = sync_reg[1];
  assign press_req = press_reg;

  always_ff @(posedge exCLK) begin
    if (RST) begin
      sync_reg  <= '0;
      vld_reg   <= '0;
      armed_reg <= 1'b0;
      state_reg <= IDLE;
      cnt_reg   <= '0;
      press_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], btn};
      vld_reg   <= {vld_reg[0], 1'b1};
      armed_reg <= armed_next;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      press_reg <= press_next;
    end
  end

  // A button already held through reset must be released before it can count as a press.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    press_next = 1'b0;
    armed_next = armed_reg | (vld_reg[1] & ~cp_s);
    case (state_reg)
      IDLE: begin
        if (cp_s && armed_reg) begin
          if (DEB_LAST == '0) begin
            state_next = HELD;
            press_next = 1'b1;
          end else begin
            state_next = PRESS_WAIT;
            cnt_next   = ONE;
          end
        end
      end
      PRESS_WAIT: begin
        if (!cp_s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == DEB_LAST) begin
          state_next = HELD;
          cnt_next   = '0;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + ONE;
        end
      end
      HELD: begin
        if (!cp_s) begin
          if (DEB_LAST == '0) begin
            state_next = IDLE;
          end else begin
            state_next = RELEASE_WAIT;
            cnt_next   = ONE;
          end
        end
      end
      RELEASE_WAIT: begin
        if (cp_s) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt_reg == DEB_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/clk_step_gen.sv
// Free-running divided clock or debounced single-step pulses, gated so that
// the downstream flip-flop stage only ever sees full-width high phases.
module clk_step_gen
  import clk_step_pkg::*;
#(
  parameter int DIV_HALF   = DEF_DIV_HALF,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int PULSE_LEN  = DEF_PULSE_LEN,
  parameter int CNT_W      = DEF_CNT_W
) (
  input logic           exCLK,
  input logic           RST,
  clk_step_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_HALF);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  logic [1:0]       en_sync_reg;
  logic [1:0]       mode_sync_reg;
  logic [CNT_W-1:0] div_cnt_reg;
  logic [CNT_W-1:0] pulse_cnt_reg;
  logic             phase_reg;
  logic             en_q_reg;
  logic             mode_q_reg;
  logic             clkout_reg;
  logic             busy_reg;
  logic             press_req;
  logic             gate_open;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_deb (
    .exCLK     (exCLK),
    .RST       (RST),
    .btn       (bus.CP),
    .press_req (press_req)
  );

  // Enable and mode may only change while the output is idle low and the divider is in its low phase.
  assign gate_open = !clkout_reg && !busy_reg && !phase_reg;

  always_ff @(posedge exCLK) begin
    if (RST) begin
      en_sync_reg   <= '0;
      mode_sync_reg <= '0;
      div_cnt_reg   <= '0;
      pulse_cnt_reg <= '0;
      phase_reg     <= 1'b0;
      en_q_reg      <= 1'b0;
      mode_q_reg    <= MODE_FREE;
      clkout_reg    <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      en_sync_reg   <= {en_sync_reg[0], bus.CLKen};
      mode_sync_reg <= {mode_sync_reg[0], bus.MODE};

      if (div_cnt_reg == DIV_LAST) begin
        div_cnt_reg <= '0;
        phase_reg   <= ~phase_reg;
      end else begin
        div_cnt_reg <= div_cnt_reg + ONE;
      end

      if (gate_open) begin
        en_q_reg   <= en_sync_reg[1];
        mode_q_reg <= mode_sync_reg[1];
      end

      if (mode_q_reg == MODE_STEP) begin
        if (busy_reg) begin
          if (pulse_cnt_reg == PULSE_LAST) begin
            busy_reg      <= 1'b0;
            clkout_reg    <= 1'b0;
            pulse_cnt_reg <= '0;
          end else begin
            pulse_cnt_reg <= pulse_cnt_reg + ONE;
          end
        end else if (press_req && en_q_reg) begin
          busy_reg      <= 1'b1;
          clkout_reg    <= 1'b1;
          pulse_cnt_reg <= '0;
        end
      end else begin
        clkout_reg    <= phase_reg & en_q_reg;
        busy_reg      <= 1'b0;
        pulse_cnt_reg <= '0;
      end
    end
  end

  assign bus.CLKout   = clkout_reg;
  assign bus.STEPBUSY = busy_reg;

endmodule

// File: doc/clk_step_gen.md
Name: clk_step_gen

Overview:
Clock-source stage that sits directly upstream of the JK flip-flop experiment stage and drives its clock input.
- Free-run mode: a slow clock divided from the board clock.
- Single-step mode: one clean pulse per debounced press of the CP push-button.
- Output is gated by CLKen without glitches or truncated pulses, so the 74LS112 model only ever sees full-width edges.

Parameters:
DIV_HALF, 27000000, divider terminal count; phase toggles when counter == DIV_HALF, so period = 2*(DIV_HALF+1) exCLK cycles
DEB_CYCLES, 270000, consecutive stable synchronized cycles needed to accept a press or a release (10 ms at 27 MHz)
PULSE_LEN, 1350000, width in exCLK cycles of a single-step pulse
CNT_W, 27, width of all internal counters; must hold max(DIV_HALF, DEB_CYCLES, PULSE_LEN)

Ports:
exCLK  input  1  board clock; sole clock of the block
RST  input  1  synchronous, active-high reset
CLKen  input  1  async slide switch; clock output enable (both modes)
MODE  input  1  async slide switch; 0 = free-run, 1 = single-step
CP  input  1  async push-button, active-high, bouncy
CLKout  output  1  registered clock to the flip-flop stage
STEPBUSY  output  1  high while a single-step pulse is being emitted

Behaviour:
Interface:
- One clock, exCLK. Reset RST is synchronous and active-high; it is sampled only on the exCLK rising edge.
- While RST = 1 at an edge: all flops clear. CLKout = 0, STEPBUSY = 0, divider count = 0, phase = 0, debounce FSM = IDLE, synchronizers = 0, latched enable/mode = 0.
- Reset mid-pulse: CLKout drops on that same edge; no pending step survives reset.

Input synchronization:
- CLKen, MODE and CP each pass through a 2-flop synchronizer.
- Synchronized values are valid 2 edges after the input changes.

Divider (always running, independent of mode):
- Count 0..DIV_HALF. At DIV_HALF the count returns to 0 and phase toggles. The count is not reset by mode or enable changes.

Gate latch, the glitch-free rule:
- en_q and mode_q load the synchronized CLKen and MODE only on a cycle where CLKout = 0 and STEPBUSY = 0 and phase = 0.
- Otherwise they hold their value.

Free-run output (mode_q = 0):
- CLKout <= phase & en_q.
- A high phase already started always completes its full DIV_HALF+1 cycles.
- A re-enable takes effect at the next rising phase toggle.

Debounce FSM (sub-module), states IDLE -> PRESS_WAIT -> HELD -> RELEASE_WAIT -> IDLE:
- IDLE: sync CP = 1 -> PRESS_WAIT with count = 1.
- PRESS_WAIT: count increments while sync CP = 1. Any 0 returns to IDLE with the count cleared. When count reaches DEB_CYCLES: go to HELD and assert press_req for exactly 1 cycle.
- HELD: sync CP = 0 -> RELEASE_WAIT.
- RELEASE_WAIT: needs DEB_CYCLES consecutive zeros to reach IDLE; any 1 returns to HELD.
- Result: exactly one press_req per physical press, however long the button is held.

Single-step output (mode_q = 1):
- press_req with en_q = 1 and STEPBUSY = 0: on the next edge CLKout = 1 and STEPBUSY = 1. Both stay high for exactly PULSE_LEN cycles, then clear together.
- press_req while STEPBUSY = 1 or en_q = 0 is dropped; nothing is queued.
- The divider phase is ignored in step mode.

Step latency: CP rising to CLKout rising = 2 + DEB_CYCLES + 1 edges.

Mode switch: the new mode takes effect only via the gate latch rule, so no partial pulse is emitted at the mode boundary.

Width rules: all counters are unsigned CNT_W bits. Comparisons are equality against the parameters, never overflow-based.

Decomposition:
- Shared package clk_step_pkg: mode encoding constants MODE_FREE = 0 and MODE_STEP = 1; debounce state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT); default constants for DIV_HALF, DEB_CYCLES, PULSE_LEN.
- One sub-module, btn_debounce: synchronizer plus FSM; outputs press_req.
- Divider, gate latch and pulse timer stay in the top level.

Test Plan (DIV_HALF=3, DEB_CYCLES=4, PULSE_LEN=5):
1. Hold RST = 1 for 3 edges, then CLKen = 1, MODE = 0 -> CLKout = 0 and STEPBUSY = 0 during reset; afterwards CLKout is periodic with 8-cycle period, 4 high / 4 low, and every high run is exactly 4 cycles.
2. Free-run: drop CLKen 1 cycle after a CLKout rise -> that high run still lasts 4 cycles, then CLKout stays 0. Reassert CLKen mid-low -> the first new high run is a full 4 cycles.
3. MODE = 1, CLKen = 1, CP held high for 20 cycles -> CLKout rises on the 7th edge after CP rises, is high for exactly 5 cycles with STEPBUSY matching, and no second pulse appears.
4. CP toggling every 2 cycles for 20 cycles, then held low -> CLKout never rises. Then a clean 10-cycle press -> exactly one 5-cycle pulse.
5. Second clean press whose press_req lands while STEPBUSY = 1 -> dropped; CLKout shows a single 5-cycle pulse. A press with CLKen = 0 -> no pulse.
6. RST asserted on cycle 2 of a step pulse -> CLKout = 0 and STEPBUSY = 0 on that edge. After release with CP still held high, no pulse is produced until CP is released and pressed again.
